copro_fxmac_pipe: RTL and testbench
===================================

Name: copro_fxmac_pipe

Overview:
- Pipelined, XLEN-generic fixed-point multiply-add and PRNG coprocessor unit for the CV-X-IF example coprocessor.
- Replaces the single-cycle FXMADD unit with a MulStages-deep multiply pipeline, valid/ready handshakes on both sides and an XLEN-scaled LFSR.
- Sits between the coprocessor issue/decoder logic and the result arbiter.

Parameters:
- XLEN, 32, datapath width; supported values are 32 and 64.
- NrRgprPorts, 3, register operands in registers_i; must be at least 3.
- MulStages, 2, register stages in the multiplier; must be at least 1.
- hartid_t, logic, hart ID type.
- id_t, logic, instruction ID type.
- registers_t, logic, operand array type: NrRgprPorts x XLEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  issue valid
- ready_o  out  1  issue ready
- registers_i  in  registers_t  rs1/rs2/rs3 in indices 0/1/2
- opcode_i  in  opcode_t  NOP/FXMADD/FXSEED/FXGEN
- funct3  in  3  shift amount, low bits
- funct2  in  2  shift amount, high bits
- hartid_i  in  hartid_t  issuing hart
- id_i  in  id_t  instruction ID
- rd_i  in  5  destination register
- valid_o  out  1  result valid
- ready_i  in  1  result accepted
- result_o  out  XLEN  result
- hartid_o  out  hartid_t  hart of result
- id_o  out  id_t  ID of result
- rd_o  out  5  destination register
- we_o  out  1  register write enable

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is synchronous and active-low: sampled only on the clk_i rising edge.
- Reset values:
  - All pipeline valid bits are 0; valid_o = 0, we_o = 0, result_o = 0, rd_o = 0, hartid_o = 0, id_o = 0.
  - LFSR state = {7'b1010101, XLEN'(1)}.
  - Reset mid-operation discards all in-flight instructions; no output is produced for them.
- Handshake:
  - stall = valid_o & ~ready_i; ready_o = ~stall.
  - Accept occurs when valid_i & ready_o.
  - On a stall the whole pipeline holds, and all outputs stay stable until ready_i.
  - Output is a valid/ready register: outputs must not change while valid_o=1 and ready_i=0.
- Latency:
  - Every accepted op reaches valid_o exactly MulStages+1 cycles after accept when there is no stall.
  - All opcodes traverse the same pipeline, so results leave in issue order. Throughput is 1 op per cycle.
- Shift amount: sh = {funct2, funct3}, range 0..31.
- FXMADD:
  - p = signed(rs1) * signed(rs2), full 2*XLEN bits.
  - q = p >>> sh (arithmetic shift), truncated to the low XLEN bits.
  - result = q + signed(rs3), wrapping modulo 2^XLEN.
  - we_o = 1, rd_o = rd_i.
- FXSEED:
  - At accept, LFSR state <= {7'b1010101, rs1}.
  - Output: result 0, we_o = 0, rd_o = 0.
- FXGEN:
  - result = {1'b0, state[XLEN-2:0]} >>> sh, using the state at accept.
  - At accept, the state advances XLEN single-bit steps.
  - we_o = 1, rd_o = rd_i.
- NOP: passes through with result 0, we_o = 0, rd_o = 0.
- Unrecognised opcode: accepted and dropped; no valid_o is produced for it.
- LFSR:
  - Width W = XLEN+7.
  - Fibonacci step: s' = {s[W-2:0], s[W-1] ^ s[T-1]}, with T = 35 for XLEN=32 and T = 65 for XLEN=64.
  - Updates happen at accept time, in order. FXSEED immediately followed by FXGEN therefore sees the seeded state.
  - An accept stalled by ~ready_o does not touch the state.

Optional Feature:
- Macro: COPRO_FXMAC_SAT_EN.
- Defined:
  - q is saturated from 2*XLEN to the signed XLEN range, instead of truncated.
  - The final add saturates to [-2^(XLEN-1), 2^(XLEN-1)-1].
- Undefined: wrapping arithmetic exactly as specified above.
- NOP, FXSEED and FXGEN are unaffected in both cases.

Decomposition:
- cvxif_instr_pkg gains:
  - the LFSR tap function/constant selected by XLEN;
  - the LFSR seed prefix constant 7'b1010101;
  - the pipeline payload struct (result, hartid, id, rd, we, op).
- Sub-module copro_lfsr_step: combinational, W- and tap-parameterised, advances the state by N steps.

Test Plan:
- FXMADD rs1=3, rs2=5, rs3=7, sh=0 (MulStages=2) -> valid_o 3 cycles after accept, result 22, we_o=1, rd_o=rd_i.
- FXMADD rs1=-8, rs2=3, rs3=0, sh=2 -> result -6 (0xFFFFFFFA).
- FXMADD rs1=rs2=0x7FFFFFFF, rs3=0x7FFFFFFF, sh=0:
  - without the macro -> result 0x80000000 (low product 1 plus rs3, wrapped);
  - with COPRO_FXMAC_SAT_EN -> 0x7FFFFFFF.
- Back-to-back FXSEED rs1=0x12345678, then FXGEN sh=0, then FXGEN sh=4 -> outputs match the golden model, in order. The second FXGEN equals its next-state word >>> 4, and bit 31 is 0.
- Issue 5 ops with ready_i=0 from cycle 2 -> ready_o drops, outputs hold stable, no LFSR advance. On ready_i=1, all results appear in order, none lost or duplicated.
- Assert rst_ni=0 for 1 cycle with 3 ops in flight -> no valid_o afterwards. A following FXGEN returns the reset-state word {1'b0, 31'h00000001}.

Source files
------------

// File: rtl/cvxif_instr_pkg.sv
// Shared opcode encoding, LFSR constants and pipeline control payload for the
// CV-X-IF example coprocessor instruction units.
package cvxif_instr_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    FXMADD = 3'd1,
    FXSEED = 3'd2,
    FXGEN  = 3'd3
  } opcode_t;

  localparam int unsigned LfsrPrefixW    = 7;
  localparam logic [6:0]  LfsrSeedPrefix = 7'b1010101;

  // Feedback tap (1-based) for the XLEN+7 bit Fibonacci LFSR.
  function automatic int unsigned lfsr_tap(input int unsigned xlen);
    return (xlen == 32'd64) ? 32'd65 : 32'd35;
  endfunction

  // Control part of the per-stage payload; datapath fields depend on XLEN and
  // the hart/ID types, so those live alongside it in the unit itself.
  typedef struct packed {
    opcode_t    op;
    logic       we;
    logic [4:0] rd;
  } fxmac_ctrl_t;

endpackage

// File: rtl/copro_lfsr_step.sv
// Combinational N-step advance of a W-bit Fibonacci LFSR with feedback from
// the MSB and tap T.
module copro_lfsr_step #(
  parameter int unsigned W = 39,
  parameter int unsigned T = 35,
  parameter int unsigned N = 32
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < N; i++) begin
      s = {s[W-2:0], s[W-1] ^ s[T-1]};
    end
    state_o = s;
  end

endmodule

// File: rtl/copro_fxmac_pipe.sv
// Pipelined fixed-point multiply-add and LFSR PRNG coprocessor unit.
// Define COPRO_FXMAC_SAT_EN for saturating FXMADD instead of wrapping.
module copro_fxmac_pipe
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NrRgprPorts = 3,
  parameter int unsigned MulStages   = 2,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  parameter type         registers_t = logic [NrRgprPorts-1:0][XLEN-1:0]
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  registers_t      registers_i,
  input  opcode_t         opcode_i,
  input  logic [2:0]      funct3,
  input  logic [1:0]      funct2,
  input  hartid_t         hartid_i,
  input  id_t             id_i,
  input  logic [4:0]      rd_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output hartid_t         hartid_o,
  output id_t             id_o,
  output logic [4:0]      rd_o,
  output logic            we_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("copro_fxmac_pipe: XLEN must be 32 or 64");
  end
  if (NrRgprPorts < 3) begin : g_bad_ports
    $error("copro_fxmac_pipe: NrRgprPorts must be at least 3");
  end
  if (MulStages < 1) begin : g_bad_stages
    $error("copro_fxmac_pipe: MulStages must be at least 1");
  end

  localparam int unsigned LfsrW = XLEN + LfsrPrefixW;
  localparam int unsigned LfsrT = lfsr_tap(XLEN);

  typedef struct packed {
    logic              valid;
    fxmac_ctrl_t       ctrl;
    logic [4:0]        sh;
    logic [XLEN-1:0]   gen;
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] prod;
  } stage_t;

  logic             stall;
  logic             accept;
  logic [4:0]       sh;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  rs3;
  logic [LfsrW-1:0] lfsr_q;
  logic [LfsrW-1:0] lfsr_d;
  logic [LfsrW-1:0] lfsr_adv;
  stage_t           stage_d;
  stage_t           last;
  stage_t           stage_q [MulStages];
  hartid_t          hart_q  [MulStages];
  id_t              id_q    [MulStages];
  logic [XLEN-1:0]  mac_res;
  logic [XLEN-1:0]  res_d;

  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall;
  assign accept  = valid_i & ready_o;
  assign sh      = {funct2, funct3};
  assign rs1     = registers_i[0];
  assign rs2     = registers_i[1];
  assign rs3     = registers_i[2];

  // Issue stage: unrecognised opcodes enter as a bubble and are thus dropped.
  always_comb begin
    stage_d         = '0;
    stage_d.ctrl.op = opcode_i;
    stage_d.sh      = sh;
    case (opcode_i)
      NOP, FXSEED: begin
        stage_d.valid = accept;
      end
      FXMADD: begin
        stage_d.valid   = accept;
        stage_d.ctrl.we = 1'b1;
        stage_d.ctrl.rd = rd_i;
        stage_d.prod    = {{XLEN{rs1[XLEN-1]}}, rs1} * {{XLEN{rs2[XLEN-1]}}, rs2};
        stage_d.addend  = rs3;
      end
      FXGEN: begin
        stage_d.valid   = accept;
        stage_d.ctrl.we = 1'b1;
        stage_d.ctrl.rd = rd_i;
        stage_d.gen     = {1'b0, lfsr_q[XLEN-2:0]} >> sh;
      end
      default: ;
    endcase
  end

  copro_lfsr_step #(
    .W(LfsrW),
    .T(LfsrT),
    .N(XLEN)
  ) u_lfsr_step (
    .state_i(lfsr_q),
    .state_o(lfsr_adv)
  );

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      case (opcode_i)
        FXSEED:  lfsr_d = {LfsrSeedPrefix, rs1};
        FXGEN:   lfsr_d = lfsr_adv;
        default: ;
      endcase
    end
  end

  assign last = stage_q[MulStages-1];

`ifdef COPRO_FXMAC_SAT_EN
  localparam logic [XLEN-1:0] SatMax = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] SatMin = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] q_full;
  logic [XLEN-1:0]   q_sat;
  logic [XLEN:0]     sum;

  // Overflow whenever the bits above the XLEN sign bit differ from it.
  always_comb begin
    q_full = $signed(last.prod) >>> last.sh;
    if (q_full[2*XLEN-1:XLEN-1] != {(XLEN+1){q_full[2*XLEN-1]}}) begin
      q_sat = q_full[2*XLEN-1] ? SatMin : SatMax;
    end else begin
      q_sat = q_full[XLEN-1:0];
    end
    sum = {q_sat[XLEN-1], q_sat} + {last.addend[XLEN-1], last.addend};
    if (sum[XLEN] != sum[XLEN-1]) begin
      mac_res = sum[XLEN] ? SatMin : SatMax;
    end else begin
      mac_res = sum[XLEN-1:0];
    end
  end
`else
  assign mac_res = XLEN'($signed(last.prod) >>> last.sh) + last.addend;
`endif

  assign res_d = (last.ctrl.op == FXMADD) ? mac_res : last.gen;

  // The whole pipe, LFSR excepted, advances only when the output is free.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MulStages; i++) begin
        stage_q[i] <= '0;
        hart_q[i]  <= '0;
        id_q[i]    <= '0;
      end
      lfsr_q   <= {LfsrSeedPrefix, XLEN'(1)};
      valid_o  <= 1'b0;
      result_o <= '0;
      we_o     <= 1'b0;
      rd_o     <= '0;
      hartid_o <= '0;
      id_o     <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      if (!stall) begin
        stage_q[0] <= stage_d;
        hart_q[0]  <= hartid_i;
        id_q[0]    <= id_i;
        for (int unsigned i = 1; i < MulStages; i++) begin
          stage_q[i] <= stage_q[i-1];
          hart_q[i]  <= hart_q[i-1];
          id_q[i]    <= id_q[i-1];
        end
        valid_o <= last.valid;
        if (last.valid) begin
          result_o <= res_d;
          we_o     <= last.ctrl.we;
          rd_o     <= last.ctrl.rd;
          hartid_o <= hart_q[MulStages-1];
          id_o     <= id_q[MulStages-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_copro_fxmac_pipe.sv
// Directed bench for copro_fxmac_pipe with an in-order expected-result queue.
module tb_copro_fxmac_pipe;
  import cvxif_instr_pkg::*;

  typedef logic [1:0] hart_t;
  typedef logic [3:0] tid_t;
  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic [4:0]  rd;
    hart_t       hart;
    tid_t        id;
  } exp_t;

`ifdef COPRO_FXMAC_SAT_EN
  localparam logic [31:0] OvfExp = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OvfExp = 32'h80000000;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_i;
  logic             ready_o;
  logic [2:0][31:0] regs;
  opcode_t          opcode;
  logic [2:0]       funct3;
  logic [1:0]       funct2;
  hart_t            hartid_i;
  tid_t             id_i;
  logic [4:0]       rd_i;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      result_o;
  hart_t            hartid_o;
  tid_t             id_o;
  logic [4:0]       rd_o;
  logic             we_o;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [38:0] m_lfsr;
  tid_t id_ctr = '0;

  always #5 clk = ~clk;

  copro_fxmac_pipe #(
    .XLEN(32),
    .NrRgprPorts(3),
    .MulStages(2),
    .hartid_t(hart_t),
    .id_t(tid_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .registers_i(regs),
    .opcode_i(opcode),
    .funct3(funct3),
    .funct2(funct2),
    .hartid_i(hartid_i),
    .id_i(id_i),
    .rd_i(rd_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .result_o(result_o),
    .hartid_o(hartid_o),
    .id_o(id_o),
    .rd_o(rd_o),
    .we_o(we_o)
  );

  function automatic logic [31:0] mac_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [4:0] sh);
    longint pa, pb, q, s;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    q  = (pa * pb) >>> sh;
`ifdef COPRO_FXMAC_SAT_EN
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    else if (q < -64'sd2147483648) q = -64'sd2147483648;
    s = q + longint'($signed(c));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
    s = q + longint'($signed(c));
`endif
    return s[31:0];
  endfunction

  function automatic logic [38:0] lfsr_model_adv(input logic [38:0] st);
    for (int k = 0; k < 32; k++) st = {st[37:0], st[38] ^ st[34]};
    return st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] sh, input logic [4:0] rd,
                       input bit use_exp = 1'b0, input logic [31:0] exp_res = '0);
    bit   acc;
    exp_t e;
    valid_i  = 1'b1;
    opcode   = op;
    regs[0]  = a;
    regs[1]  = b;
    regs[2]  = c;
    funct3   = sh[2:0];
    funct2   = sh[4:3];
    rd_i     = rd;
    hartid_i = hart_t'($urandom_range(0, 3));
    id_i     = id_ctr;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        acc    = 1'b1;
        e      = '0;
        e.hart = hartid_i;
        e.id   = id_ctr;
        case (op)
          FXMADD: begin
            e.res = use_exp ? exp_res : mac_model(a, b, c, sh);
            e.we  = 1'b1;
            e.rd  = rd;
            exp_q.push_back(e);
          end
          FXGEN: begin
            e.res  = use_exp ? exp_res : ({1'b0, m_lfsr[30:0]} >> sh);
            e.we   = 1'b1;
            e.rd   = rd;
            m_lfsr = lfsr_model_adv(m_lfsr);
            exp_q.push_back(e);
          end
          FXSEED: begin
            m_lfsr = {7'b1010101, a};
            exp_q.push_back(e);
          end
          NOP:     exp_q.push_back(e);
          default: ;
        endcase
      end
      tick();
    end
    valid_i = 1'b0;
    id_ctr  = id_ctr + 4'd1;
    check("issue_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t o, e;
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      o = {result_o, we_o, rd_o, hartid_o, id_o};
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_out: got %h expected none", o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        assert (o === e) else begin
          n_err++;
          $error("FAIL result id%0d: got %h expected %h", e.id, o, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] snap;
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    regs     = '0;
    opcode   = NOP;
    funct3   = '0;
    funct2   = '0;
    hartid_i = '0;
    id_i     = '0;
    rd_i     = '0;
    m_lfsr   = {7'b1010101, 32'h1};
    repeat (2) tick();
    @(negedge clk);
    check("rst_outputs", 64'({valid_o, we_o, result_o, rd_o, hartid_o, id_o}), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    tick();
    rst_n = 1'b1;

    // Latency: result visible exactly three cycles after the accept cycle.
    issue(FXMADD, 32'd3, 32'd5, 32'd7, 5'd0, 5'd9, 1'b1, 32'd22);
    @(negedge clk); check("lat_c1", 64'(valid_o), 64'd0);
    tick();
    @(negedge clk); check("lat_c2", 64'(valid_o), 64'd0);
    tick();
    @(negedge clk); check("lat_c3", 64'(valid_o), 64'd1);
    tick();

    issue(FXMADD, 32'hFFFFFFF8, 32'd3, 32'd0, 5'd2, 5'd3, 1'b1, 32'hFFFFFFFA);
    issue(FXMADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 5'd4, 1'b1, OvfExp);
    issue(FXMADD, 32'h80000000, 32'h80000000, 32'd0, 5'd31, 5'd5);
    issue(FXMADD, 32'h80000000, 32'h80000000, 32'h80000000, 5'd31, 5'd6);
    for (int i = 0; i < 6; i++) begin
      issue(FXMADD, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(1, 31)));
    end
    drain();

    // Seed then generate back to back, plus an unrecognised opcode.
    issue(FXSEED, 32'h12345678, 32'd0, 32'd0, 5'd0, 5'd7);
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd0, 5'd10);
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd4, 5'd11);
    issue(opcode_t'(3'd5), 32'hDEADBEEF, 32'd0, 32'd0, 5'd0, 5'd12);
    issue(NOP, 32'd1, 32'd2, 32'd3, 5'd1, 5'd13);
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd31, 5'd14);
    drain();

    // Back-pressure: output stalls while later ops sit in the pipe.
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd1, 5'd12);
    issue(FXMADD, $urandom, $urandom, $urandom, 5'd3, 5'd13);
    ready_i = 1'b0;
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd2, 5'd14);
    valid_i = 1'b1;
    opcode  = FXGEN;
    funct3  = 3'd3;
    funct2  = 2'd0;
    rd_i    = 5'd15;
    @(negedge clk);
    check("stall_valid", 64'(valid_o), 64'd1);
    snap = 64'({valid_o, result_o, we_o, rd_o, hartid_o, id_o});
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("stall_ready", 64'(ready_o), 64'd0);
      check("stall_hold", 64'({valid_o, result_o, we_o, rd_o, hartid_o, id_o}), snap);
    end
    tick();
    ready_i = 1'b1;
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd3, 5'd15);
    issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 5'd16);
    drain();

    // Reset with three ops in flight: they vanish and the LFSR restarts.
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd0, 5'd17);
    issue(FXMADD, 32'd11, 32'd13, 32'd1, 5'd0, 5'd18);
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd0, 5'd19);
    rst_n = 1'b0;
    exp_q.delete();
    m_lfsr = {7'b1010101, 32'h1};
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(valid_o), 64'd0);
      tick();
    end
    issue(FXGEN, 32'd0, 32'd0, 32'd0, 5'd0, 5'd20, 1'b1, 32'h00000001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
